// File: rtl/wb_resp_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_resp_pkg
// Brief   : Shared cycle/burst type codes and FSM states for wb_reg_responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_resp_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    BURST = 2'd3
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_reg_responder_if.sv
//------------------------------------------------------------------------------
// Module  : wb_reg_responder_if
// Brief   : Wishbone B4 bus bundle for one peripheral window.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_reg_responder_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_burst_adr_gen.sv
//------------------------------------------------------------------------------
// Module  : wb_burst_adr_gen
// Brief   : Next word index for Wishbone bursts (linear or 4/8/16 wrap).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_burst_adr_gen
  import wb_resp_pkg::*;
(
  input  logic [3:0] i_idx,
  input  logic [1:0] i_bte,
  output logic [3:0] o_next_idx,
  output logic       o_overflow
);

  logic [3:0] w_inc;
  assign w_inc = i_idx + 4'd1;

  // Wrap modes keep the block-aligned upper bits and only advance the low bits.
  always_comb begin
    o_next_idx = w_inc;
    o_overflow = 1'b0;
    case (i_bte)
      BTE_LINEAR: o_overflow = (i_idx == 4'hF);
      BTE_WRAP4:  o_next_idx = {i_idx[3:2], w_inc[1:0]};
      BTE_WRAP8:  o_next_idx = {i_idx[3],   w_inc[2:0]};
      default:    o_next_idx = w_inc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_reg_responder.sv
//------------------------------------------------------------------------------
// Module  : wb_reg_responder
// Brief   : Wishbone B4 slave register window with wait states and bursts.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_reg_responder
  import wb_resp_pkg::*;
#(
  parameter int           NUM_REGS    = 16,
  parameter int           WAIT_STATES = 0,
  parameter logic [15:0]  RO_MASK     = 16'h0000,
  parameter logic [511:0] RESET_VAL   = 512'h0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_reg_responder_if.slave     wb,
  input  logic [NUM_REGS*32-1:0] hw_status_i,
  output logic [NUM_REGS*32-1:0] ctrl_o,
  output logic [NUM_REGS-1:0]    wr_strobe_o
);

  localparam logic [4:0] c_num_regs  = 5'(NUM_REGS);
  localparam logic [3:0] c_wait_load = 4'(WAIT_STATES - 1);

  wb_state_e     r_state, w_state_nxt;
  logic [3:0]    r_wait_cnt, w_wait_nxt;
  logic [3:0]    r_nxt_idx;
  logic          r_nxt_ovf;
  logic          r_we;
  logic          r_ack, r_err;
  logic [31:0]   r_dat;
  logic [NUM_REGS-1:0] r_strobe;

  logic          w_req, w_in_burst, w_beat, w_beat_err, w_beat_we, w_more, w_wr_go;
  logic [3:0]    w_beat_idx, w_gen_idx;
  logic          w_gen_ovf;
  logic [31:0]   w_view [16];
  logic [NUM_REGS-1:0] w_hit;
  logic          w_unused;

  assign w_unused = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0], hw_status_i};

  assign w_req      = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_in_burst = (r_state == BURST);
  // Burst beats follow the predicted address, not the master's adr.
  assign w_beat_idx = w_in_burst ? r_nxt_idx : wb.wb_adr_i[5:2];
  assign w_beat_we  = w_in_burst ? r_we : wb.wb_we_i;
  assign w_beat_err = (w_in_burst & r_nxt_ovf) | ({1'b0, w_beat_idx} >= c_num_regs);
  assign w_more     = (wb.wb_cti_i == CTI_INCR) & ~w_beat_err;
  assign w_wr_go    = w_beat & w_beat_we & ~w_beat_err;

  wb_burst_adr_gen u_adr_gen (
    .i_idx      (w_beat_idx),
    .i_bte      (wb.wb_bte_i),
    .o_next_idx (w_gen_idx),
    .o_overflow (w_gen_ovf)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = WAIT;
            w_wait_nxt  = c_wait_load;
          end else begin
            w_beat      = 1'b1;
            w_state_nxt = w_more ? BURST : ACK;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == 4'd0) begin
          w_beat      = 1'b1;
          w_state_nxt = w_more ? BURST : ACK;
        end else begin
          w_wait_nxt  = r_wait_cnt - 4'd1;
        end
      end
      ACK: w_state_nxt = IDLE;
      BURST: begin
        if (!wb.wb_cyc_i) begin
          w_state_nxt = IDLE;
        end else if (wb.wb_stb_i) begin
          w_beat = 1'b1;
          if (!w_more) w_state_nxt = ACK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= 32'h0;
      r_strobe  <= '0;
      r_nxt_idx <= 4'd0;
      r_nxt_ovf <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_ack    <= w_beat & ~w_beat_err;
      r_err    <= w_beat & w_beat_err;
      r_strobe <= w_hit;
      if (w_beat) begin
        r_dat     <= w_beat_err ? 32'h0 : w_view[w_beat_idx];
        r_nxt_idx <= w_gen_idx;
        r_nxt_ovf <= w_gen_ovf;
        r_we      <= w_beat_we;
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_reg
    if (i < NUM_REGS) begin : g_impl
      if (!RO_MASK[i]) begin : g_rw
        logic [31:0] r_q;
        assign w_hit[i] = w_wr_go & (w_beat_idx == 4'(i));
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
          if (wb_rst_i) begin
            r_q <= RESET_VAL[32*i +: 32];
          end else if (w_hit[i]) begin
            for (int b = 0; b < 4; b++) begin
              if (wb.wb_sel_i[b]) r_q[8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
            end
          end
        end
        assign w_view[i]         = r_q;
        assign ctrl_o[32*i +: 32] = r_q;
      end else begin : g_ro
        // Read-only slot: writes are acked but dropped, no strobe.
        assign w_hit[i]          = 1'b0;
        assign w_view[i]         = hw_status_i[32*i +: 32];
        assign ctrl_o[32*i +: 32] = 32'h0;
      end
    end else begin : g_none
      assign w_view[i] = 32'h0;
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_rty_o = 1'b0;
  assign wr_strobe_o = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_wb_reg_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_wb_reg_responder
// Brief   : Directed self-checking bench for wb_reg_responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_reg_responder;
  import wb_resp_pkg::*;

  localparam logic [511:0] RV = {
    32'h0000_000F, 32'h0000_000E, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0000_0077, 32'h0000_0066, 32'h0000_5550, 32'h0000_0044,
    32'hA5A5_0003, 32'h0000_0000, 32'h0000_0011, 32'h0000_1000};
  localparam logic [15:0] RO = 16'h0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [511:0] hw_status;
  logic [511:0] ctrl0, ctrl3;
  logic [15:0]  strobe0, strobe3;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_reg_responder_if bus0 ();
  wb_reg_responder_if bus3 ();

  wb_reg_responder #(.NUM_REGS(16), .WAIT_STATES(0), .RO_MASK(RO), .RESET_VAL(RV)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus0.slave),
    .hw_status_i(hw_status), .ctrl_o(ctrl0), .wr_strobe_o(strobe0));

  wb_reg_responder #(.NUM_REGS(16), .WAIT_STATES(3), .RO_MASK(RO), .RESET_VAL(RV)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus3.slave),
    .hw_status_i(hw_status), .ctrl_o(ctrl3), .wr_strobe_o(strobe3));

  task automatic idle_bus();
    bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0; bus0.wb_sel_i = 4'h0;
    bus0.wb_adr_i = 32'h0; bus0.wb_dat_i = 32'h0; bus0.wb_cti_i = CTI_CLASSIC; bus0.wb_bte_i = BTE_LINEAR;
    bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0; bus3.wb_we_i = 1'b0; bus3.wb_sel_i = 4'h0;
    bus3.wb_adr_i = 32'h0; bus3.wb_dat_i = 32'h0; bus3.wb_cti_i = CTI_CLASSIC; bus3.wb_bte_i = BTE_LINEAR;
  endtask

  // Classic cycle on the zero-wait instance; lat = edges until ack/err (0 = none within budget).
  task automatic cycle0(input logic [3:0] idx, input logic we, input logic [3:0] sel,
                        input logic [31:0] d, output logic ack, output logic err,
                        output logic [31:0] rd, output logic [15:0] stb_seen, output int lat);
    bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1; bus0.wb_adr_i = {26'h0, idx, 2'b00};
    bus0.wb_we_i = we; bus0.wb_sel_i = sel; bus0.wb_dat_i = d; bus0.wb_cti_i = CTI_CLASSIC;
    ack = 1'b0; err = 1'b0; rd = 32'h0; stb_seen = 16'h0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus0.wb_ack_o || bus0.wb_err_o) begin
        ack = bus0.wb_ack_o; err = bus0.wb_err_o; rd = bus0.wb_dat_o;
        stb_seen = strobe0; lat = c;
        break;
      end
    end
    bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [511:0] exp;
    exp = RV;
    exp[191:160] = 32'h0;
    n_vec++; if (bus0.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack got %0b want 0", bus0.wb_ack_o); end
    n_vec++; if (bus0.wb_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", bus0.wb_err_o); end
    n_vec++; if (bus0.wb_dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat got %h want 0", bus0.wb_dat_o); end
    n_vec++; if (bus0.wb_rty_o !== 1'b0) begin n_err++; $display("FAIL reset_rty got %0b want 0", bus0.wb_rty_o); end
    n_vec++; if (strobe0 !== 16'h0) begin n_err++; $display("FAIL reset_strobe got %h want 0", strobe0); end
    n_vec++; if (ctrl0 !== exp) begin n_err++; $display("FAIL reset_ctrl got %h want %h", ctrl0, exp); end
    n_vec++; if (bus3.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack3 got %0b want 0", bus3.wb_ack_o); end
  endtask

  task automatic test_classic_read();
    logic a, e; logic [31:0] rd; logic [15:0] s; int lat;
    cycle0(4'd3, 1'b0, 4'hF, 32'h0, a, e, rd, s, lat);
    n_vec++; if (lat !== 1 || a !== 1'b1 || e !== 1'b0) begin n_err++; $display("FAIL rd3_ack got lat=%0d ack=%0b err=%0b want lat=1 ack=1 err=0", lat, a, e); end
    n_vec++; if (rd !== 32'hA5A5_0003) begin n_err++; $display("FAIL rd3_dat got %h want a5a50003", rd); end
    n_vec++; if (bus0.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rd3_ack_low got %0b want 0", bus0.wb_ack_o); end
  endtask

  task automatic test_classic_write();
    logic a, e; logic [31:0] rd; logic [15:0] s; int lat;
    cycle0(4'd2, 1'b1, 4'b0101, 32'hDEAD_BEEF, a, e, rd, s, lat);
    n_vec++; if (lat !== 1 || a !== 1'b1) begin n_err++; $display("FAIL wr2_ack got lat=%0d ack=%0b want lat=1 ack=1", lat, a); end
    n_vec++; if (s !== 16'h0004) begin n_err++; $display("FAIL wr2_strobe got %h want 0004", s); end
    n_vec++; if (strobe0 !== 16'h0) begin n_err++; $display("FAIL wr2_strobe_low got %h want 0", strobe0); end
    n_vec++; if (ctrl0[95:64] !== 32'h00AD_00EF) begin n_err++; $display("FAIL wr2_ctrl got %h want 00ad00ef", ctrl0[95:64]); end
    cycle0(4'd2, 1'b0, 4'hF, 32'h0, a, e, rd, s, lat);
    n_vec++; if (rd !== 32'h00AD_00EF || lat !== 1) begin n_err++; $display("FAIL wr2_readback got %h lat=%0d want 00ad00ef lat=1", rd, lat); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd; logic seen;
    bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1; bus3.wb_adr_i = 32'h0; bus3.wb_we_i = 1'b0;
    lat = 0; rd = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus3.wb_ack_o) begin lat = c; rd = bus3.wb_dat_o; break; end
    end
    bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0;
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL ws3_latency got %0d want 4", lat); end
    n_vec++; if (rd !== 32'h0000_1000) begin n_err++; $display("FAIL ws3_dat got %h want 00001000", rd); end
    @(posedge clk); #1;
    // Abandon the request after two sampled edges.
    bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1; bus3.wb_adr_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus3.wb_ack_o || bus3.wb_err_o) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL ws3_abort got ack=1 want none"); end
    bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1; bus3.wb_adr_i = 32'd12;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus3.wb_ack_o) begin lat = c; rd = bus3.wb_dat_o; break; end
    end
    bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0;
    n_vec++; if (lat !== 4 || rd !== 32'hA5A5_0003) begin n_err++; $display("FAIL ws3_reissue got lat=%0d dat=%h want lat=4 dat=a5a50003", lat, rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap4_burst();
    logic [3:0]  idx [4];
    logic [31:0] exp [4];
    idx = '{4'd6, 4'd7, 4'd4, 4'd5};
    exp = '{32'h66, 32'h77, 32'h44, 32'h55};
    bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1; bus0.wb_we_i = 1'b0; bus0.wb_bte_i = BTE_WRAP4;
    for (int b = 0; b < 4; b++) begin
      bus0.wb_adr_i = {26'h0, idx[b], 2'b00};
      bus0.wb_cti_i = (b == 3) ? CTI_EOB : CTI_INCR;
      @(posedge clk); #1;
      n_vec++;
      if (bus0.wb_ack_o !== 1'b1 || bus0.wb_dat_o !== exp[b]) begin
        n_err++; $display("FAIL wrap4_beat%0d got ack=%0b dat=%h want ack=1 dat=%h", b, bus0.wb_ack_o, bus0.wb_dat_o, exp[b]);
      end
    end
    @(posedge clk); #1;
    n_vec++; if (bus0.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL wrap4_end got ack=%0b want 0", bus0.wb_ack_o); end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_linear_burst();
    bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1; bus0.wb_we_i = 1'b0;
    bus0.wb_bte_i = BTE_LINEAR; bus0.wb_cti_i = CTI_INCR; bus0.wb_adr_i = 32'd56;
    @(posedge clk); #1;
    n_vec++; if (bus0.wb_ack_o !== 1'b1 || bus0.wb_dat_o !== 32'hE) begin n_err++; $display("FAIL lin_beat14 got ack=%0b dat=%h want ack=1 dat=e", bus0.wb_ack_o, bus0.wb_dat_o); end
    bus0.wb_adr_i = 32'd60;
    @(posedge clk); #1;
    n_vec++; if (bus0.wb_ack_o !== 1'b1 || bus0.wb_dat_o !== 32'hF) begin n_err++; $display("FAIL lin_beat15 got ack=%0b dat=%h want ack=1 dat=f", bus0.wb_ack_o, bus0.wb_dat_o); end
    bus0.wb_adr_i = 32'd0;
    @(posedge clk); #1;
    n_vec++; if (bus0.wb_err_o !== 1'b1 || bus0.wb_ack_o !== 1'b0 || bus0.wb_dat_o !== 32'h0) begin
      n_err++; $display("FAIL lin_overflow got err=%0b ack=%0b dat=%h want err=1 ack=0 dat=0", bus0.wb_err_o, bus0.wb_ack_o, bus0.wb_dat_o);
    end
    @(posedge clk); #1;
    n_vec++; if (bus0.wb_err_o !== 1'b0 || bus0.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL lin_end got err=%0b ack=%0b want 0 0", bus0.wb_err_o, bus0.wb_ack_o); end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_ro_write();
    logic a, e; logic [31:0] rd; logic [15:0] s; int lat;
    cycle0(4'd5, 1'b1, 4'hF, 32'h0000_1234, a, e, rd, s, lat);
    n_vec++; if (lat !== 1 || a !== 1'b1 || s !== 16'h0) begin n_err++; $display("FAIL ro5_write got lat=%0d ack=%0b strobe=%h want lat=1 ack=1 strobe=0", lat, a, s); end
    cycle0(4'd5, 1'b0, 4'hF, 32'h0, a, e, rd, s, lat);
    n_vec++; if (rd !== 32'h55 || a !== 1'b1) begin n_err++; $display("FAIL ro5_read got %h ack=%0b want 00000055 ack=1", rd, a); end
    n_vec++; if (ctrl0[191:160] !== 32'h0) begin n_err++; $display("FAIL ro5_ctrl got %h want 0", ctrl0[191:160]); end
  endtask

  task automatic test_reset_mid_burst();
    logic a, e; logic [31:0] rd; logic [15:0] s; int lat;
    logic [511:0] exp;
    exp = RV;
    exp[191:160] = 32'h0;
    bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1; bus0.wb_we_i = 1'b0;
    bus0.wb_bte_i = BTE_LINEAR; bus0.wb_cti_i = CTI_INCR; bus0.wb_adr_i = 32'd0;
    @(posedge clk); #1;
    n_vec++; if (bus0.wb_ack_o !== 1'b1 || bus0.wb_dat_o !== 32'h1000) begin n_err++; $display("FAIL rstb_beat0 got ack=%0b dat=%h want ack=1 dat=1000", bus0.wb_ack_o, bus0.wb_dat_o); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus0.wb_ack_o !== 1'b0 || bus0.wb_err_o !== 1'b0) begin n_err++; $display("FAIL rstb_async got ack=%0b err=%0b want 0 0", bus0.wb_ack_o, bus0.wb_err_o); end
    n_vec++; if (ctrl0 !== exp) begin n_err++; $display("FAIL rstb_regs got %h want %h", ctrl0, exp); end
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle0(4'd2, 1'b0, 4'hF, 32'h0, a, e, rd, s, lat);
    n_vec++; if (rd !== 32'h0 || a !== 1'b1 || lat !== 1) begin n_err++; $display("FAIL rstb_reg2 got %h ack=%0b lat=%0d want 0 ack=1 lat=1", rd, a, lat); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    hw_status = '0;
    hw_status[191:160] = 32'h55;
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_classic_read();
    test_classic_write();
    test_wait_states();
    test_wrap4_burst();
    test_linear_burst();
    test_ro_write();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_reg_responder.md
Name: wb_reg_responder

Overview:
- Wishbone B4 responder (slave end) for one peripheral window of the IO mux: 16 x 32-bit register file with byte selects, programmable wait states and registered ack/err.
- Supports classic cycles plus incrementing bursts with linear and 4/8/16-beat wrap.
- Read-only registers return live hardware status; writable registers drive peripheral control outputs.
- Reusable template for the GPIO, rojobot and pushbutton ports hung off the 64-byte (mask ffffffc0) windows.

Parameters:
- NUM_REGS, 16, implemented word registers (1..16); word index = wb_adr_i[5:2]
- WAIT_STATES, 0, idle cycles inserted before the first ack/err of each cycle (0..15)
- RO_MASK, 16'h0000, bit i set -> register i is read-only and reads from hw_status_i
- RESET_VAL, 512'h0, flattened reset values of the writable registers (reg i at [32i+31:32i])

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  32  byte address; only [5:2] decoded (the mux already selected the window)
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane enables
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  acknowledge, registered
- wb_err_o  out  1  error, registered
- wb_rty_o  out  1  tied 0
- hw_status_i  in  NUM_REGS*32  live values returned for RO registers
- ctrl_o  out  NUM_REGS*32  current writable register contents (RO slots drive 0)
- wr_strobe_o  out  NUM_REGS  one-cycle pulse per register on each accepted write

Behaviour:
- Reset (async): all regs = RESET_VAL; ack, err, wr_strobe_o = 0; dat_o = 0; FSM = IDLE. Reset mid-cycle drops ack/err immediately; no write completes.
- Req = cyc & stb. Idx = adr[5:2] for the first beat. Idx >= NUM_REGS -> error beat.
- FSM states:
  - IDLE: on req, go to WAIT if WAIT_STATES>0 (counter loaded), else to ACK.
  - WAIT: count down; at 0 go to ACK; if req drops, go to IDLE.
  - ACK: drive ack (or err) for one cycle.
    - Classic (cti 000 or 111): return to IDLE. Ack is never high two consecutive cycles, so the master drops stb or re-issues.
    - cti 010 and not err: go to BURST.
  - BURST: ack high every cycle while req and cti != 111.
    - Beat with cti=111: final ack, then IDLE.
    - req low: ack low, state holds (master stall); resumes with no extra wait states.
    - cyc low: IDLE next cycle, no ack.
    - Any beat with idx out of range: err instead of ack, burst terminated, then IDLE.
- Read latency: first data = 1 + WAIT_STATES cycles after req is sampled. dat_o is registered alongside ack and comes from the predicted beat address.
- Next address: 4-bit word counter increments by 1. bte wraps within the aligned 4/8/16-word block, replacing the low 2/3/4 bits. Linear stops at the end of the window; the beat past word 15 gives err.
- Writes: committed on the cycle ack is asserted with we=1, using the beat address. Per-byte update from sel; sel=0 still acks and writes nothing. wr_strobe_o[idx] pulses the same cycle. Writes to RO registers ack and are discarded; no strobe.
- Read of an RO register returns hw_status_i sampled in the ack cycle's preceding edge.
- err carries dat_o = 0.
- Mixed we within a burst is not supported; we is sampled on the first beat.

Decomposition:
- Package wb_resp_pkg:
  - CTI_CLASSIC/CTI_INCR/CTI_EOB constants
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16 constants
  - state enum {IDLE, WAIT, ACK, BURST}
- Sub-module wb_burst_adr_gen: combinational next-word-index from (idx, bte), plus an overflow flag for linear bursts.

Test Plan:
- Reset, then classic read of reg 3 (RESET_VAL 0xA5A5_0003), WAIT_STATES=0 -> ack exactly 1 cycle after stb, dat_o=0xA5A50003, ack low the next cycle.
- Classic write 0xDEADBEEF to reg 2 with sel=4'b0101, prior value 0 -> reg2 = 0x00AD00EF, wr_strobe_o[2] pulses 1 cycle, ctrl_o slice matches.
- WAIT_STATES=3, read reg 0 -> ack on 4th cycle after req. Dropping stb after 2 cycles -> no ack, FSM IDLE.
- Incrementing wrap4 read burst starting at word 6, 4 beats with last cti=111 -> consecutive acks, data from words 6,7,4,5, then ack low.
- Linear burst starting at word 14, NUM_REGS=16 -> acks for 14 and 15, err on the third beat, burst ends.
- Write 0x1234 to RO reg 5 (hw_status_i slice = 0x55) -> ack, no strobe, read-back returns 0x55. Assert wb_rst_i mid-burst -> ack and err fall immediately, regs = RESET_VAL.
